nic2noc_vc_tracker: RTL and testbench

- Per-VC bookkeeping stage between the NiC slave-side fifo_out_buffers and the router input link.
- Records which fifo_out_buffer owns each allocated output VC, and routes router credits back to that buffer (credit_signal_o / fifo_pointed_o).
- Registers the outgoing flit onto the link.
- Holds a released VC in DRAINING until every downstream credit has returned; only then reports it free to the VC allocator.

---
 rtl/nic2noc_vc_tracker_if.sv | 48 ++++
 rtl/nic2noc_vc_tracker.sv | 173 +++++++++++++++++
 tb/tb_nic2noc_vc_tracker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/nic2noc_vc_tracker_if.sv
// ============================================================================
// Module      : nic2noc_vc_tracker_if
// Description : Handshake bundle between the NiC fifo_out_buffers, the VC
//               allocator and the router input link, as seen by the VC tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

interface nic2noc_vc_tracker_if #(
    parameter int N_TOT_OF_VC            = 6,
    parameter int N_BITS_FIFO_OUT_BUFFER = 3,
    parameter int FLIT_W                 = `FLIT_WIDTH
);
    // VC allocator side
    logic [N_TOT_OF_VC-1:0]                        g_fifo_pointer_i;
    logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] g_fifo_out_buffer_id_i;
    logic [N_TOT_OF_VC-1:0]                        release_pointer_i;
    logic [N_TOT_OF_VC-1:0]                        vc_idle_o;

    // Credit return path towards the fifo_out_buffers
    logic [N_TOT_OF_VC-1:0]                        credit_i;
    logic [N_TOT_OF_VC-1:0]                        credit_signal_o;
    logic [N_TOT_OF_VC*N_BITS_FIFO_OUT_BUFFER-1:0] fifo_pointed_o;

    // Flit path towards the router
    logic [FLIT_W-1:0]                             flit_i;
    logic                                          is_valid_i;
    logic [FLIT_W-1:0]                             out_link_o;
    logic                                          is_valid_o;

    modport master (
        output g_fifo_pointer_i, g_fifo_out_buffer_id_i, release_pointer_i,
        output credit_i, flit_i, is_valid_i,
        input  vc_idle_o, credit_signal_o, fifo_pointed_o, out_link_o, is_valid_o
    );

    modport slave (
        input  g_fifo_pointer_i, g_fifo_out_buffer_id_i, release_pointer_i,
        input  credit_i, flit_i, is_valid_i,
        output vc_idle_o, credit_signal_o, fifo_pointed_o, out_link_o, is_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/nic2noc_vc_tracker.sv
// ============================================================================
// Module      : nic2noc_vc_tracker
// Description : Per-VC ownership / outstanding-credit tracker between the NiC
//               fifo_out_buffers and the router link. Optional protocol
//               checker (err_o) enabled by NIC2NOC_PROTOCOL_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

module nic2noc_vc_tracker #(
    parameter int N_TOT_OF_VC            = 6,
    parameter int N_BITS_FIFO_OUT_BUFFER = 3,
    parameter int N_BITS_CREDIT          = 4,
    parameter int BUFFER_DEPTH           = 4,
    parameter int VC_ID_LSB              = 0
) (
    input  wire logic               clk,
    input  wire logic               rst,
    nic2noc_vc_tracker_if.slave     bus
`ifdef NIC2NOC_PROTOCOL_CHECK_EN
    ,
    output logic                    err_o
`endif
);

    localparam int NB = N_BITS_FIFO_OUT_BUFFER;
    localparam logic [N_BITS_CREDIT-1:0] c_BUF_DEPTH = N_BITS_CREDIT'(BUFFER_DEPTH);
    localparam logic [N_BITS_CREDIT-1:0] c_CNT_ZERO  = '0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DRAINING = 2'd2
    } state_t;

    state_t                     r_state     [N_TOT_OF_VC];
    state_t                     w_state_nxt [N_TOT_OF_VC];
    logic [N_BITS_CREDIT-1:0]   r_cnt       [N_TOT_OF_VC];
    logic [N_BITS_CREDIT-1:0]   w_cnt_nxt   [N_TOT_OF_VC];
    logic [NB-1:0]              r_owner     [N_TOT_OF_VC];

    logic [N_TOT_OF_VC-1:0]     w_owner_ld;
    logic [N_TOT_OF_VC-1:0]     w_inc;
    logic [N_TOT_OF_VC-1:0]     w_dec;
    logic [N_TOT_OF_VC-1:0]     w_at_full;
    logic [N_TOT_OF_VC-1:0]     w_at_zero;
    logic [N_TOT_OF_VC-1:0]     w_is_active;
    logic [N_TOT_OF_VC-1:0]     r_vc_idle;

    logic [`FLIT_WIDTH-1:0]     r_out_link;
    logic                       r_is_valid;

    // Per-VC counter update and credit forwarding
    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_vc
        assign w_inc[v]       = bus.is_valid_i & bus.flit_i[VC_ID_LSB+v];
        assign w_dec[v]       = bus.credit_i[v];
        assign w_at_full[v]   = (r_cnt[v] == c_BUF_DEPTH);
        assign w_at_zero[v]   = (r_cnt[v] == c_CNT_ZERO);
        assign w_is_active[v] = (r_state[v] == ST_ACTIVE);

        assign w_cnt_nxt[v] = (w_inc[v] && !w_dec[v] && !w_at_full[v]) ? r_cnt[v] + 1'b1 :
                              (w_dec[v] && !w_inc[v] && !w_at_zero[v]) ? r_cnt[v] - 1'b1 :
                                                                         r_cnt[v];

        assign bus.credit_signal_o[v]       = w_dec[v] & w_is_active[v];
        assign bus.fifo_pointed_o[v*NB +: NB] = r_owner[v];
    end

    // Next-state logic: transitions out of ACTIVE/DRAINING look at the
    // post-update counter so a same-cycle final credit frees the VC at once.
    always_comb begin
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            w_state_nxt[v] = r_state[v];
            w_owner_ld[v]  = 1'b0;
            case (r_state[v])
                ST_IDLE: begin
                    if (bus.g_fifo_pointer_i[v]) begin
                        w_state_nxt[v] = ST_ACTIVE;
                        w_owner_ld[v]  = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (bus.release_pointer_i[v]) begin
                        w_state_nxt[v] = (w_cnt_nxt[v] == c_CNT_ZERO) ? ST_IDLE : ST_DRAINING;
                    end
                end
                ST_DRAINING: begin
                    if (w_cnt_nxt[v] == c_CNT_ZERO) begin
                        w_state_nxt[v] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[v] = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                r_state[v] <= ST_IDLE;
                r_cnt[v]   <= '0;
                r_owner[v] <= '0;
            end
            r_vc_idle <= '1;
        end else begin
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                r_state[v]   <= w_state_nxt[v];
                r_cnt[v]     <= w_cnt_nxt[v];
                r_vc_idle[v] <= (w_state_nxt[v] == ST_IDLE);
                if (w_owner_ld[v]) begin
                    r_owner[v] <= bus.g_fifo_out_buffer_id_i[v*NB +: NB];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_link <= '0;
            r_is_valid <= 1'b0;
        end else begin
            r_is_valid <= bus.is_valid_i;
            if (bus.is_valid_i) begin
                r_out_link <= bus.flit_i;
            end
        end
    end

    assign bus.out_link_o = r_out_link;
    assign bus.is_valid_o = r_is_valid;
    assign bus.vc_idle_o  = r_vc_idle;

`ifdef NIC2NOC_PROTOCOL_CHECK_EN
    logic [N_TOT_OF_VC-1:0] w_is_idle;
    logic [N_TOT_OF_VC-1:0] w_vc_field;
    logic                   w_vc_onehot;
    logic                   w_err_evt;
    logic                   r_err;

    for (genvar v = 0; v < N_TOT_OF_VC; v++) begin : g_chk
        assign w_is_idle[v] = (r_state[v] == ST_IDLE);
    end

    assign w_vc_field  = bus.flit_i[VC_ID_LSB +: N_TOT_OF_VC];
    assign w_vc_onehot = (w_vc_field != '0) &&
                         ((w_vc_field & (w_vc_field - 1'b1)) == '0);

    assign w_err_evt = (|(bus.g_fifo_pointer_i & ~w_is_idle)) |
                       (|(w_inc & ~w_is_active))               |
                       (|(w_inc & w_at_full))                  |
                       (|(w_dec & w_at_zero))                  |
                       (bus.is_valid_i & ~w_vc_onehot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nic2noc_vc_tracker.sv
// ============================================================================
// Module      : tb_nic2noc_vc_tracker
// Description : Directed self-checking bench for nic2noc_vc_tracker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif

module tb_nic2noc_vc_tracker;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    int   n_fail;

    nic2noc_vc_tracker_if bus ();

`ifdef NIC2NOC_PROTOCOL_CHECK_EN
    logic err;
`endif

    nic2noc_vc_tracker dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
`ifdef NIC2NOC_PROTOCOL_CHECK_EN
        ,
        .err_o (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.g_fifo_pointer_i       = '0;
        bus.g_fifo_out_buffer_id_i = '0;
        bus.release_pointer_i      = '0;
        bus.credit_i               = '0;
        bus.flit_i                 = '0;
        bus.is_valid_i             = 1'b0;
    endtask

    task automatic send_flit(input logic [15:0] f);
        bus.flit_i     = f;
        bus.is_valid_i = 1'b1;
        tick();
        chk("flit_out", 64'(bus.out_link_o), 64'(f));
        chk("flit_vld", 64'(bus.is_valid_o), 64'd1);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clear_inputs();
        tick();
        tick();
        chk("rst_idle",    64'(bus.vc_idle_o),       64'h3F);
        chk("rst_valid",   64'(bus.is_valid_o),      64'd0);
        chk("rst_link",    64'(bus.out_link_o),      64'd0);
        chk("rst_credit",  64'(bus.credit_signal_o), 64'd0);
        chk("rst_pointed", 64'(bus.fifo_pointed_o),  64'd0);
`ifdef NIC2NOC_PROTOCOL_CHECK_EN
        chk("rst_err", 64'(err), 64'd0);
`endif
        rst = 1'b0;

        // Grant VC2 to buffer 5
        bus.g_fifo_pointer_i       = 6'b000100;
        bus.g_fifo_out_buffer_id_i = 18'h140;
        tick();
        clear_inputs();
        chk("g2_idle",    64'(bus.vc_idle_o),      64'h3B);
        chk("g2_pointed", 64'(bus.fifo_pointed_o), 64'h140);

        // Three flits on VC2, then one credit
        send_flit(16'hA004);
        send_flit(16'hB104);
        send_flit(16'hC204);
        clear_inputs();
        tick();
        chk("hold_vld",  64'(bus.is_valid_o), 64'd0);
        chk("hold_link", 64'(bus.out_link_o), 64'hC204);
        bus.credit_i = 6'b000100;
        #1;
        chk("vc2_cr_fwd", 64'(bus.credit_signal_o), 64'h04);
        tick();
        clear_inputs();

        // Release VC2 with two outstanding, drain with two credits
        bus.release_pointer_i = 6'b000100;
        tick();
        clear_inputs();
        chk("drain_idle0", 64'(bus.vc_idle_o), 64'h3B);
        bus.credit_i = 6'b000100;
        #1;
        chk("drain_cr0", 64'(bus.credit_signal_o), 64'h00);
        tick();
        chk("drain_idle1", 64'(bus.vc_idle_o), 64'h3B);
        #1;
        chk("drain_cr1", 64'(bus.credit_signal_o), 64'h00);
        tick();
        clear_inputs();
        chk("drain_idle2", 64'(bus.vc_idle_o), 64'h3F);

        // VC1: grant to buffer 3, one flit, release + credit together
        bus.g_fifo_pointer_i       = 6'b000010;
        bus.g_fifo_out_buffer_id_i = 18'h018;
        tick();
        clear_inputs();
        chk("g1_idle",    64'(bus.vc_idle_o),      64'h3D);
        chk("g1_pointed", 64'(bus.fifo_pointed_o), 64'h158);
        send_flit(16'h5502);
        clear_inputs();
        bus.release_pointer_i = 6'b000010;
        bus.credit_i          = 6'b000010;
        #1;
        chk("vc1_cr_fwd", 64'(bus.credit_signal_o), 64'h02);
        tick();
        clear_inputs();
        chk("vc1_direct_idle", 64'(bus.vc_idle_o), 64'h3F);

        // VC0: grant to buffer 6, fill to depth, overflow, re-grant
        bus.g_fifo_pointer_i       = 6'b000001;
        bus.g_fifo_out_buffer_id_i = 18'h006;
        tick();
        clear_inputs();
        chk("g0_pointed", 64'(bus.fifo_pointed_o), 64'h15E);
        send_flit(16'h1001);
        send_flit(16'h2001);
        send_flit(16'h3001);
        send_flit(16'h4001);
`ifdef NIC2NOC_PROTOCOL_CHECK_EN
        chk("err_before_ovf", 64'(err), 64'd0);
`endif
        send_flit(16'h5001);
        clear_inputs();
        bus.g_fifo_pointer_i       = 6'b000001;
        bus.g_fifo_out_buffer_id_i = 18'h001;
        tick();
        clear_inputs();
        chk("regrant_owner", 64'(bus.fifo_pointed_o), 64'h15E);
        chk("regrant_idle",  64'(bus.vc_idle_o),      64'h3E);
`ifdef NIC2NOC_PROTOCOL_CHECK_EN
        chk("err_after_ovf", 64'(err), 64'd1);
`endif
        // Four credits must empty a saturated counter of four
        for (int i = 0; i < 4; i++) begin
            bus.credit_i = 6'b000001;
            #1;
            chk("vc0_cr_fwd", 64'(bus.credit_signal_o), 64'h01);
            tick();
        end
        clear_inputs();
        bus.release_pointer_i = 6'b000001;
        tick();
        clear_inputs();
        chk("vc0_sat_idle", 64'(bus.vc_idle_o), 64'h3F);
`ifdef NIC2NOC_PROTOCOL_CHECK_EN
        chk("err_sticky", 64'(err), 64'd1);
`endif

        // VC3 active with a flit on the link, then asynchronous reset
        bus.g_fifo_pointer_i       = 6'b001000;
        bus.g_fifo_out_buffer_id_i = 18'h400;
        tick();
        clear_inputs();
        send_flit(16'h7008);
        clear_inputs();
        chk("pre_rst_idle", 64'(bus.vc_idle_o), 64'h37);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",   64'(bus.is_valid_o),     64'd0);
        chk("arst_idle",    64'(bus.vc_idle_o),      64'h3F);
        chk("arst_link",    64'(bus.out_link_o),     64'd0);
        chk("arst_pointed", 64'(bus.fifo_pointed_o), 64'd0);
`ifdef NIC2NOC_PROTOCOL_CHECK_EN
        chk("arst_err", 64'(err), 64'd0);
`endif
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 64'(bus.vc_idle_o), 64'h3F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
